// File: rtl/music_pkg.sv
// Shared types and constants for the note sequencer.
package music_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam logic [3:0] NOTE_REST = 4'h0;
  localparam logic [3:0] NOTE_END  = 4'hF;

  localparam int DEFAULT_NUM_NOTES = 10;
  localparam int DEFAULT_NOTE_W    = 4;

endpackage

// File: rtl/duration_timer.sv
// Loadable down-counter that times note and gap phases.
module duration_timer #(
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] loadVal,
  output logic          expired
);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // The sequencer only consults expired in PLAY/GAP, where a reload is itself
  // decided from expired; masking with load here would close a combinational loop.
  assign expired = (count == '0);

endmodule

// File: rtl/music_sequencer.sv
// Plays a latched song word as a series of timed notes separated by silent gaps.
module music_sequencer
  import music_pkg::*;
#(
  parameter int NUM_NOTES   = DEFAULT_NUM_NOTES,
  parameter int NOTE_W      = DEFAULT_NOTE_W,
  parameter int NOTE_CYCLES = 4000000,
  parameter int GAP_CYCLES  = 400000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ce,
  input  logic                        start,
  input  logic [NUM_NOTES*NOTE_W-1:0] flattenedMCUout,
  output logic [NOTE_W-1:0]           noteOut,
  output logic                        noteOn,
  output logic [3:0]                  slotIdx,
  output logic                        makingMusic,
  output logic                        songDone,
  output seq_state_t                  state
);

  localparam int WORD_W    = NUM_NOTES * NOTE_W;
  localparam int MAX_CYC   = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int TW        = $clog2((MAX_CYC > 2) ? MAX_CYC : 2);
  localparam int GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [TW-1:0]     NOTE_VAL  = TW'(NOTE_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_VAL   = TW'(GAP_LOAD);
  localparam logic [3:0]        LAST_SLOT = 4'(NUM_NOTES - 1);
  localparam logic [NOTE_W-1:0] CODE_END  = NOTE_W'(NOTE_END);
  localparam logic [NOTE_W-1:0] CODE_REST = NOTE_W'(NOTE_REST);

  function automatic logic [NOTE_W-1:0] slot_code(input logic [WORD_W-1:0] w,
                                                   input logic [3:0] idx);
    slot_code = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (idx == 4'(i)) slot_code = w[(NUM_NOTES-1-i)*NOTE_W +: NOTE_W];
    end
  endfunction

  logic [WORD_W-1:0] word_q;
  logic [NOTE_W-1:0] first_code;
  logic [NOTE_W-1:0] next_code;
  logic [3:0]        next_slot;
  logic              advance_end;
  logic              accept;
  logic              do_adv;
  logic              expired;
  logic              load;
  logic [TW-1:0]     load_val;

  // start is a single-cycle request, accepted only in IDLE with ce low;
  // there is no back-pressure, a refused start is simply dropped.
  assign accept      = (state == IDLE) && start && !ce;
  assign first_code  = slot_code(flattenedMCUout, 4'd0);
  assign next_slot   = slotIdx + 4'd1;
  assign next_code   = slot_code(word_q, next_slot);
  assign advance_end = (slotIdx == LAST_SLOT) || (next_code == CODE_END);
  assign do_adv      = !ce && expired &&
                       (((state == PLAY) && (GAP_CYCLES == 0)) || (state == GAP));

  always_comb begin
    load     = 1'b0;
    load_val = NOTE_VAL;
    case (state)
      IDLE: load = accept && (first_code != CODE_END);
      PLAY: begin
        if (!ce && expired && (GAP_CYCLES > 0)) begin
          load     = 1'b1;
          load_val = GAP_VAL;
        end else if (do_adv && !advance_end) begin
          load = 1'b1;
        end
      end
      GAP:     load = do_adv && !advance_end;
      default: load = 1'b0;
    endcase
  end

  duration_timer #(.TW(TW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .loadVal (load_val),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      word_q      <= '0;
      slotIdx     <= '0;
      noteOut     <= '0;
      noteOn      <= 1'b0;
      makingMusic <= 1'b0;
      songDone    <= 1'b0;
    end else begin
      songDone <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            word_q  <= flattenedMCUout;
            slotIdx <= 4'd0;
            if (first_code == CODE_END) begin
              state    <= DONE;
              songDone <= 1'b1;
            end else begin
              state       <= PLAY;
              noteOut     <= first_code;
              noteOn      <= (first_code != CODE_REST);
              makingMusic <= 1'b1;
            end
          end
        end
        PLAY, GAP: begin
          if (ce) begin
            state       <= IDLE;
            noteOut     <= '0;
            noteOn      <= 1'b0;
            makingMusic <= 1'b0;
          end else if (state == PLAY && expired && (GAP_CYCLES > 0)) begin
            state   <= GAP;
            noteOut <= '0;
            noteOn  <= 1'b0;
          end else if (do_adv) begin
            if (advance_end) begin
              state       <= DONE;
              songDone    <= 1'b1;
              noteOut     <= '0;
              noteOn      <= 1'b0;
              makingMusic <= 1'b0;
            end else begin
              state   <= PLAY;
              slotIdx <= next_slot;
              noteOut <= next_code;
              noteOn  <= (next_code != CODE_REST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with short note/gap durations.
module tb_music_sequencer;
  import music_pkg::*;

  logic        clk;
  logic        reset;
  logic        ce;
  logic        start;
  logic [39:0] flattenedMCUout;
  logic [3:0]  noteOut;
  logic        noteOn;
  logic [3:0]  slotIdx;
  logic        makingMusic;
  logic        songDone;
  seq_state_t  state;

  int checks;
  int failures;

  music_sequencer #(
    .NUM_NOTES(10), .NOTE_W(4), .NOTE_CYCLES(4), .GAP_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start),
    .flattenedMCUout(flattenedMCUout), .noteOut(noteOut), .noteOn(noteOn),
    .slotIdx(slotIdx), .makingMusic(makingMusic), .songDone(songDone),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plays a word and checks every cycle up to one past the songDone cycle.
  // done_c: cycle (after the start edge) holding songDone; disturb: cycle at
  // which a stray start with a different word is injected (0 = none).
  task automatic run_song(input logic [39:0] word, input int done_c,
                          input logic [3:0] last_slot, input int disturb,
                          input string name);
    logic [3:0] code, eo, es;
    logic       eon, emm, esd;
    seq_state_t est;
    int         slot, ph;
    @(negedge clk);
    start = 1'b1;
    flattenedMCUout = word;
    step();
    start = 1'b0;
    for (int c = 1; c <= done_c + 1; c++) begin
      if (c < done_c) begin
        slot = (c - 1) / 6;
        ph   = (c - 1) % 6;
        code = word[(9 - slot) * 4 +: 4];
        eo   = (ph < 4) ? code : 4'h0;
        eon  = (ph < 4) && (code != 4'h0);
        emm  = 1'b1;
        esd  = 1'b0;
        es   = 4'(slot);
        est  = (ph < 4) ? PLAY : GAP;
      end else begin
        eo  = 4'h0;
        eon = 1'b0;
        emm = 1'b0;
        esd = (c == done_c);
        es  = last_slot;
        est = (c == done_c) ? DONE : IDLE;
      end
      checks++;
      if ({noteOut, noteOn, slotIdx, makingMusic, songDone, state} !==
          {eo, eon, es, emm, esd, est}) begin
        failures++;
        $display("FAIL %s cycle %0d: got note=%h on=%b slot=%0d mm=%b done=%b st=%0d, want note=%h on=%b slot=%0d mm=%b done=%b st=%0d",
                 name, c, noteOut, noteOn, slotIdx, makingMusic, songDone, state,
                 eo, eon, es, emm, esd, est);
      end
      if (disturb != 0 && c == disturb) begin
        start = 1'b1;
        flattenedMCUout = 40'hF0F0F0F0F0;
      end
      if (disturb != 0 && c == disturb + 1) start = 1'b0;
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    ce = 1'b0;
    flattenedMCUout = 40'h123456789A;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({noteOut, noteOn, slotIdx, makingMusic, songDone, state} !== {4'h0, 1'b0, 4'h0, 1'b0, 1'b0, IDLE}) begin
        failures++;
        $display("FAIL reset cycle %0d: got note=%h on=%b slot=%0d mm=%b done=%b st=%0d, want all 0 / IDLE",
                 i, noteOut, noteOn, slotIdx, makingMusic, songDone, state);
      end
    end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_full_song();
    run_song(40'h123456789A, 61, 4'd9, 0, "full_song");
  endtask

  task automatic test_end_marker();
    run_song(40'h12F4567890, 13, 4'd1, 0, "end_marker");
  endtask

  task automatic test_rest_slot();
    run_song(40'h1020000000, 61, 4'd9, 0, "rest_slot");
  endtask

  task automatic test_first_end();
    run_song(40'hF123456789, 1, 4'd0, 0, "first_end");
  endtask

  task automatic test_start_in_play();
    run_song(40'h123456789A, 61, 4'd9, 3, "start_in_play");
  endtask

  task automatic test_abort();
    int seen_done;
    @(negedge clk);
    start = 1'b1;
    flattenedMCUout = 40'h123456789A;
    step();
    start = 1'b0;
    for (int c = 1; c < 14; c++) step();
    checks++;
    if ({noteOut, noteOn, makingMusic, slotIdx} !== {4'h3, 1'b1, 1'b1, 4'd2}) begin
      failures++;
      $display("FAIL abort_pre: got note=%h on=%b mm=%b slot=%0d, want note=3 on=1 mm=1 slot=2",
               noteOut, noteOn, makingMusic, slotIdx);
    end
    ce = 1'b1;
    step();
    ce = 1'b0;
    checks++;
    if ({noteOut, noteOn, makingMusic, songDone, state} !== {4'h0, 1'b0, 1'b0, 1'b0, IDLE}) begin
      failures++;
      $display("FAIL abort_next: got note=%h on=%b mm=%b done=%b st=%0d, want 0/0/0/0/IDLE",
               noteOut, noteOn, makingMusic, songDone, state);
    end
    seen_done = 0;
    for (int c = 0; c < 70; c++) begin
      step();
      if (songDone !== 1'b0 || makingMusic !== 1'b0) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      failures++;
      $display("FAIL abort_quiet: got %0d active cycles after abort, want 0", seen_done);
    end
  endtask

  task automatic test_start_with_ce();
    @(negedge clk);
    start = 1'b1;
    ce = 1'b1;
    flattenedMCUout = 40'h123456789A;
    step();
    start = 1'b0;
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({makingMusic, noteOn, songDone, state} !== {1'b0, 1'b0, 1'b0, IDLE}) begin
        failures++;
        $display("FAIL start_with_ce cycle %0d: got mm=%b on=%b done=%b st=%0d, want 0/0/0/IDLE",
                 i, makingMusic, noteOn, songDone, state);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_gap();
    @(negedge clk);
    start = 1'b1;
    flattenedMCUout = 40'h123456789A;
    step();
    start = 1'b0;
    for (int c = 1; c < 5; c++) step();
    checks++;
    if (state !== GAP || makingMusic !== 1'b1) begin
      failures++;
      $display("FAIL reset_gap_pre: got st=%0d mm=%b, want GAP mm=1", state, makingMusic);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({noteOut, noteOn, slotIdx, makingMusic, songDone, state} !== {4'h0, 1'b0, 4'h0, 1'b0, 1'b0, IDLE}) begin
      failures++;
      $display("FAIL reset_gap: got note=%h on=%b slot=%0d mm=%b done=%b st=%0d, want all 0 / IDLE",
               noteOut, noteOn, slotIdx, makingMusic, songDone, state);
    end
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    ce = 1'b0;
    start = 1'b0;
    flattenedMCUout = '0;
    test_reset();
    test_full_song();
    test_end_marker();
    test_rest_slot();
    test_first_end();
    test_start_in_play();
    test_abort();
    test_start_with_ce();
    test_reset_mid_gap();
    test_full_song();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
